// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the ID-stage immediate controller.
// Opcode fields are the leading instruction bits each class is matched on.
package imm_pkg;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_I    = 3'd1,
        SEL_D    = 3'd2,
        SEL_CB   = 3'd3,
        SEL_B    = 3'd4,
        SEL_MOVZ = 3'd5
    } imm_sel_t;

    // I-class, matched on [31:22]
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
    localparam logic [9:0]  OP_SUBIS = 10'b1111000100;
    // D-class, matched on [31:21]
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    // CB-class, matched on [31:24]
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    // B-class, matched on [31:26]
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    // MOVZ, matched on [31:23]
    localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
    // R-type, matched on [31:21]
    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_EOR   = 11'b11001010000;
    localparam logic [10:0] OP_LSL   = 11'b11010011011;
    localparam logic [10:0] OP_LSR   = 11'b11010011010;
    localparam logic [10:0] OP_BR    = 11'b11010110000;

    function automatic logic is_rtype(input logic [10:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_LSL, OP_LSR, OP_BR};
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word -> class, extended immediate,
// ALU operand-B select and unknown-opcode flag (not yet qualified by valid).
module imm_decode
    import imm_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] i_instr,
    output imm_sel_t           o_sel,
    output logic [DATA_W-1:0]  o_imm,
    output logic               o_use_imm,
    output logic               o_unknown
);

    logic [DATA_W-1:0] w_movz_base;
    logic [5:0]        w_movz_shamt;

    assign w_movz_base  = DATA_W'(i_instr[20:5]);
    assign w_movz_shamt = {i_instr[22:21], 4'b0000};

    // First match wins; unmatched words fall through as NONE with imm=0.
    always_comb begin
        o_sel     = SEL_NONE;
        o_imm     = '0;
        o_use_imm = 1'b0;
        o_unknown = 1'b0;
        if (i_instr[31:22] inside {OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS}) begin
            o_sel     = SEL_I;
            o_imm     = DATA_W'(i_instr[21:10]);
            o_use_imm = 1'b1;
        end else if (i_instr[31:21] inside {OP_LDUR, OP_STUR}) begin
            o_sel     = SEL_D;
            o_imm     = {{(DATA_W-9){i_instr[20]}}, i_instr[20:12]};
            o_use_imm = 1'b1;
        end else if (i_instr[31:24] inside {OP_CBZ, OP_CBNZ, OP_BCOND}) begin
            o_sel = SEL_CB;
            o_imm = {{(DATA_W-21){i_instr[23]}}, i_instr[23:5], 2'b00};
        end else if (i_instr[31:26] inside {OP_B, OP_BL}) begin
            o_sel = SEL_B;
            o_imm = {{(DATA_W-28){i_instr[25]}}, i_instr[25:0], 2'b00};
        end else if (i_instr[31:23] == OP_MOVZ) begin
            o_sel     = SEL_MOVZ;
            o_imm     = w_movz_base << w_movz_shamt;
            o_use_imm = 1'b1;
        end else begin
            o_unknown = !is_rtype(i_instr[31:21]);
        end
    end

endmodule

// File: rtl/imm_stage_ctrl.sv
// ID/EX boundary register for the decoded immediate and its control bits.
// Update order each edge: reset, then flush, then stall (hold), then load.
module imm_stage_ctrl
    import imm_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [INSTR_W-1:0] id_instr,
    input  logic               stall,
    input  logic               flush,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [2:0]         ex_imm_sel,
    output logic               ex_use_imm,
    output logic               ex_illegal
);

    imm_sel_t          w_sel;
    logic [DATA_W-1:0] w_imm;
    logic              w_use_imm;
    logic              w_unknown;

    logic              r_valid;
    logic [DATA_W-1:0] r_imm;
    imm_sel_t          r_sel;
    logic              r_use_imm;
    logic              r_illegal;

    imm_decode #(
        .DATA_W  (DATA_W),
        .INSTR_W (INSTR_W)
    ) u_decode (
        .i_instr   (id_instr),
        .o_sel     (w_sel),
        .o_imm     (w_imm),
        .o_use_imm (w_use_imm),
        .o_unknown (w_unknown)
    );

    // Bubbles carry all-zero control so EX can use the fields without gating.
    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && !id_valid)) begin
            r_valid   <= 1'b0;
            r_imm     <= '0;
            r_sel     <= SEL_NONE;
            r_use_imm <= 1'b0;
            r_illegal <= 1'b0;
        end else if (!stall) begin
            r_valid   <= 1'b1;
            r_imm     <= w_imm;
            r_sel     <= w_sel;
            r_use_imm <= w_use_imm;
            r_illegal <= w_unknown;
        end
    end

    assign ex_valid   = r_valid;
    assign ex_imm     = r_imm;
    assign ex_imm_sel = r_sel;
    assign ex_use_imm = r_use_imm;
    assign ex_illegal = r_illegal;

endmodule

// File: tb/tb_imm_stage_ctrl.sv
// Bench for imm_stage_ctrl: directed vector table, stall/flush/reset sequences,
// and randomized traffic checked against an arithmetic reference model.
module tb_imm_stage_ctrl;
    import imm_pkg::*;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [63:0] ex_imm;
    logic [2:0]  ex_imm_sel;
    logic        ex_use_imm;
    logic        ex_illegal;

    int checks = 0;
    int errors = 0;

    imm_stage_ctrl #(.DATA_W(64), .INSTR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .stall      (stall),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_imm     (ex_imm),
        .ex_imm_sel (ex_imm_sel),
        .ex_use_imm (ex_use_imm),
        .ex_illegal (ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        e_valid;
        logic [63:0] e_imm;
        logic [2:0]  e_sel;
        logic        e_use;
        logic        e_ill;
    } vec_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] imm;
        logic [2:0]  sel;
        logic        use_i;
        logic        ill;
    } exp_t;

    vec_t vecs[14];
    exp_t exp_q[$];

    int unsigned i_ops[4]  = '{'h244, 'h2C4, 'h344, 'h3C4};
    int unsigned d_ops[2]  = '{'h7C2, 'h7C0};
    int unsigned cb_ops[3] = '{'hB4, 'hB5, 'h54};
    int unsigned b_ops[2]  = '{'h05, 'h25};
    int unsigned r_ops[8]  = '{'h458, 'h658, 'h450, 'h550, 'h650, 'h69B, 'h69A, 'h6B0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".valid"},   64'(ex_valid),   64'(e.valid));
        chk({tag, ".imm"},     ex_imm,          e.imm);
        chk({tag, ".sel"},     64'(ex_imm_sel), 64'(e.sel));
        chk({tag, ".use_imm"}, 64'(ex_use_imm), 64'(e.use_i));
        chk({tag, ".illegal"}, 64'(ex_illegal), 64'(e.ill));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic v, input logic [31:0] w,
                         input logic st, input logic fl);
        reset    = rst;
        id_valid = v;
        id_instr = w;
        stall    = st;
        flush    = fl;
    endtask

    function automatic longint sext(input longint f, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (f >= half) ? f - (half * 2) : f;
    endfunction

    // Decoded fields for a valid word, computed from the class rules with integer arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        int unsigned u;
        u = w;
        e = '{valid: 1'b1, imm: 64'd0, sel: SEL_NONE, use_i: 1'b0, ill: 1'b0};
        if ((u >> 22) inside {i_ops[0], i_ops[1], i_ops[2], i_ops[3]}) begin
            e.sel = SEL_I; e.use_i = 1'b1;
            e.imm = 64'((u >> 10) & 'hFFF);
        end else if ((u >> 21) inside {d_ops[0], d_ops[1]}) begin
            e.sel = SEL_D; e.use_i = 1'b1;
            e.imm = 64'(sext(longint'((u >> 12) & 'h1FF), 9));
        end else if ((u >> 24) inside {cb_ops[0], cb_ops[1], cb_ops[2]}) begin
            e.sel = SEL_CB;
            e.imm = 64'(sext(longint'((u >> 5) & 'h7FFFF), 19) * 4);
        end else if ((u >> 26) inside {b_ops[0], b_ops[1]}) begin
            e.sel = SEL_B;
            e.imm = 64'(sext(longint'(u & 'h3FFFFFF), 26) * 4);
        end else if ((u >> 23) == 'h1A5) begin
            e.sel = SEL_MOVZ; e.use_i = 1'b1;
            e.imm = 64'(longint'((u >> 5) & 'hFFFF) << (16 * ((u >> 21) & 3)));
        end else begin
            e.ill = !((u >> 21) inside {r_ops[0], r_ops[1], r_ops[2], r_ops[3],
                                        r_ops[4], r_ops[5], r_ops[6], r_ops[7]});
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        int unsigned r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return (i_ops[$urandom_range(0, 3)] << 22) | (r & 'h3FFFFF);
            1: return (d_ops[$urandom_range(0, 1)] << 21) | (r & 'h1FFFFF);
            2: return (cb_ops[$urandom_range(0, 2)] << 24) | (r & 'hFFFFFF);
            3: return (b_ops[$urandom_range(0, 1)] << 26) | (r & 'h3FFFFFF);
            4: return ('h1A5 << 23) | (r & 'h7FFFFF);
            5: return (r_ops[$urandom_range(0, 7)] << 21) | (r & 'h1FFFFF);
            default: return r;
        endcase
    endfunction

    exp_t bubble = '{valid: 1'b0, imm: 64'd0, sel: SEL_NONE, use_i: 1'b0, ill: 1'b0};

    initial begin
        exp_t e;
        exp_t held;
        exp_t mdl;
        logic rst_r, v_r, st_r, fl_r;
        logic [31:0] w_r;

        vecs[0]  = '{32'h913FFC41, 1, 1, 64'h0000_0000_0000_0FFF, SEL_I,    1, 0};
        vecs[1]  = '{32'hF85F8000, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, SEL_D,    1, 0};
        vecs[2]  = '{32'h17FFFFFF, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, SEL_B,    0, 0};
        vecs[3]  = '{32'hD2D7DDE0, 1, 1, 64'h0000_BEEF_0000_0000, SEL_MOVZ, 1, 0};
        vecs[4]  = '{32'hFFFFFFFF, 1, 1, 64'h0,                   SEL_NONE, 0, 1};
        vecs[5]  = '{32'hFFFFFFFF, 0, 0, 64'h0,                   SEL_NONE, 0, 0};
        vecs[6]  = '{32'h8B030041, 1, 1, 64'h0,                   SEL_NONE, 0, 0};
        vecs[7]  = '{32'hB4FFFFE0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, SEL_CB,   0, 0};
        vecs[8]  = '{32'h54800000, 1, 1, 64'hFFFF_FFFF_FFF0_0000, SEL_CB,   0, 0};
        vecs[9]  = '{32'hD2FFFFE0, 1, 1, 64'hFFFF_0000_0000_0000, SEL_MOVZ, 1, 0};
        vecs[10] = '{32'hF1000000, 1, 1, 64'h0,                   SEL_I,    1, 0};
        vecs[11] = '{32'hF80FF000, 1, 1, 64'h0000_0000_0000_00FF, SEL_D,    1, 0};
        vecs[12] = '{32'h96000000, 1, 1, 64'hFFFF_FFFF_F800_0000, SEL_B,    0, 0};
        vecs[13] = '{32'hD61F0000, 1, 1, 64'h0,                   SEL_NONE, 0, 0};

        drive(1, 1, 32'h913FFC41, 0, 0);
        step();
        step();
        chk_all("reset", bubble);

        foreach (vecs[i]) begin
            drive(0, vecs[i].valid, vecs[i].instr, 0, 0);
            step();
            e = '{valid: vecs[i].e_valid, imm: vecs[i].e_imm, sel: vecs[i].e_sel,
                  use_i: vecs[i].e_use, ill: vecs[i].e_ill};
            chk_all($sformatf("vec%0d", i), e);
        end

        // Stall holds the loaded ADDI; a concurrent flush still wins.
        drive(0, 1, 32'h913FFC41, 0, 0);
        step();
        held = '{valid: 1'b1, imm: 64'hFFF, sel: SEL_I, use_i: 1'b1, ill: 1'b0};
        chk_all("stall_load", held);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 32'h17FFFFFF, 1, 0);
            step();
            chk_all($sformatf("stall_hold%0d", k), held);
        end
        drive(0, 1, 32'h17FFFFFF, 1, 1);
        step();
        chk_all("stall_flush", bubble);

        // Reset mid-stream, asserted together with stall and a valid word.
        drive(0, 1, 32'hFFFFFFFF, 0, 0);
        step();
        drive(1, 1, 32'hD2D7DDE0, 1, 0);
        step();
        chk_all("mid_reset", bubble);

        // Randomized traffic; the model tracks the ID/EX slot contents.
        mdl = bubble;
        for (int n = 0; n < 400; n++) begin
            rst_r = ($urandom_range(0, 49) == 0);
            fl_r  = ($urandom_range(0, 9) == 0);
            st_r  = ($urandom_range(0, 4) == 0);
            v_r   = ($urandom_range(0, 3) != 0);
            w_r   = rand_instr();
            if (rst_r || fl_r)   mdl = bubble;
            else if (st_r)       mdl = mdl;
            else if (!v_r)       mdl = bubble;
            else                 mdl = ref_decode(w_r);
            exp_q.push_back(mdl);
            drive(rst_r, v_r, w_r, st_r, fl_r);
            step();
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rand_queue_empty actual=0 required=1");
            end else begin
                e = exp_q.pop_front();
                chk_all($sformatf("rand%0d", n), e);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
